// File: rtl/quan_credit_scheduler_if.sv
// Handshake and configuration bundle between the quantisation-pipeline controller and its
// environment. The environment is the master side and the scheduler is the slave side.
interface quan_credit_scheduler_if #(
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int WIDTH_BIAS_RAM_ADDRA  = 8
);
  logic                             Start;
  logic                             Leaky_REG;
  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG;
  logic                             Fifo_Ready;
  logic                             Out_Pop;
  logic                             EN_Rd_Fifo;
  logic [WIDTH_BIAS_RAM_ADDRA-1:0]  bias_addrb;
  logic                             Busy;
  logic                             Done;
  logic                             Credit_Err;

  modport master (
    output Start, Leaky_REG, Row_Num_Out_REG, Channel_Out_Num_REG, Fifo_Ready, Out_Pop,
    input  EN_Rd_Fifo, bias_addrb, Busy, Done, Credit_Err
  );

  modport slave (
    input  Start, Leaky_REG, Row_Num_Out_REG, Channel_Out_Num_REG, Fifo_Ready, Out_Pop,
    output EN_Rd_Fifo, bias_addrb, Busy, Done, Credit_Err
  );
endinterface

// File: rtl/quan_credit_scheduler.sv
// Credit-based issue scheduler for the fixed-latency quantisation pipeline: it only reads the
// input FIFO when the output FIFO is certain to have room, and it steps the parameter address per group.
module quan_credit_scheduler #(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int WIDTH_BIAS_RAM_ADDRA  = 8,
  parameter int OUT_FIFO_DEPTH        = 32,
  parameter int WIDTH_CREDIT          = 6,
  parameter int BIAS_RD_LAT           = 3,
  parameter int LAT_ZERO              = 11,
  parameter int LAT_LEAKY             = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  quan_credit_scheduler_if.slave bus
);

  localparam int DRAIN_MAX = (LAT_LEAKY > LAT_ZERO) ? LAT_LEAKY : LAT_ZERO;
  localparam int DRAIN_W   = $clog2(DRAIN_MAX + 1);
  localparam int SETTLE_W  = $clog2(BIAS_RD_LAT + 1);

  localparam logic [WIDTH_CREDIT-1:0] CREDIT_FULL  = WIDTH_CREDIT'(OUT_FIFO_DEPTH);
  localparam logic [SETTLE_W-1:0]     SETTLE_LAST  = SETTLE_W'(BIAS_RD_LAT - 1);
  // The DONE state and the registered Done flag together account for the final two cycles of latency.
  localparam logic [DRAIN_W-1:0]      DRAIN_ZERO   = DRAIN_W'(LAT_ZERO - 2);
  localparam logic [DRAIN_W-1:0]      DRAIN_LEAKY  = DRAIN_W'(LAT_LEAKY - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                           state_r, state_nxt_s;
  logic [WIDTH_FEATURE_SIZE-1:0]    rows_r, pix_cnt_r;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] groups_r, group_cnt_r;
  logic                             leaky_r;
  logic [WIDTH_BIAS_RAM_ADDRA-1:0]  bias_r;
  logic [SETTLE_W-1:0]              settle_cnt_r;
  logic [DRAIN_W-1:0]               drain_cnt_r;
  logic [WIDTH_CREDIT-1:0]          credit_r;
  logic                             err_r, busy_r, done_r;

  logic issue_s, last_pix_s, last_grp_s;
  logic start_acc_s, grp_adv_s, fin_issue_s;

  assign issue_s    = (state_r == ST_RUN) && bus.Fifo_Ready && (credit_r != {WIDTH_CREDIT{1'b0}});
  assign last_pix_s = (pix_cnt_r == rows_r - WIDTH_FEATURE_SIZE'(1));
  assign last_grp_s = (group_cnt_r == groups_r - WIDTH_CHANNEL_NUM_REG'(1));

  // Next-state decode plus the per-cycle events that steer the counters.
  always_comb begin
    state_nxt_s = state_r;
    start_acc_s = 1'b0;
    grp_adv_s   = 1'b0;
    fin_issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) begin
          start_acc_s = 1'b1;
          if ((bus.Row_Num_Out_REG == {WIDTH_FEATURE_SIZE{1'b0}}) ||
              (bus.Channel_Out_Num_REG == {WIDTH_CHANNEL_NUM_REG{1'b0}})) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_PRIME;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (issue_s && last_pix_s) begin
          if (last_grp_s) begin
            fin_issue_s = 1'b1;
            state_nxt_s = ST_DRAIN;
          end else begin
            grp_adv_s   = 1'b1;
            state_nxt_s = ST_PRIME;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Job shadow registers, pixel/group counters and the parameter address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_r      <= {WIDTH_FEATURE_SIZE{1'b0}};
      groups_r    <= {WIDTH_CHANNEL_NUM_REG{1'b0}};
      leaky_r     <= 1'b0;
      pix_cnt_r   <= {WIDTH_FEATURE_SIZE{1'b0}};
      group_cnt_r <= {WIDTH_CHANNEL_NUM_REG{1'b0}};
      bias_r      <= {WIDTH_BIAS_RAM_ADDRA{1'b0}};
    end else begin
      if (start_acc_s) begin
        rows_r      <= bus.Row_Num_Out_REG;
        groups_r    <= bus.Channel_Out_Num_REG;
        leaky_r     <= bus.Leaky_REG;
        pix_cnt_r   <= {WIDTH_FEATURE_SIZE{1'b0}};
        group_cnt_r <= {WIDTH_CHANNEL_NUM_REG{1'b0}};
        bias_r      <= {WIDTH_BIAS_RAM_ADDRA{1'b0}};
      end else if (grp_adv_s) begin
        pix_cnt_r   <= {WIDTH_FEATURE_SIZE{1'b0}};
        group_cnt_r <= group_cnt_r + WIDTH_CHANNEL_NUM_REG'(1);
        bias_r      <= bias_r + WIDTH_BIAS_RAM_ADDRA'(1);
      end else if (issue_s) begin
        pix_cnt_r   <= pix_cnt_r + WIDTH_FEATURE_SIZE'(1);
      end
    end
  end

  // Parameter-settle and pipeline-drain timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_r <= {SETTLE_W{1'b0}};
      drain_cnt_r  <= {DRAIN_W{1'b0}};
    end else begin
      if (state_r == ST_PRIME) begin
        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
      end else begin
        settle_cnt_r <= {SETTLE_W{1'b0}};
      end
      if (fin_issue_s) begin
        drain_cnt_r <= leaky_r ? DRAIN_ZERO : DRAIN_LEAKY;
      end else if ((state_r == ST_DRAIN) && (drain_cnt_r != {DRAIN_W{1'b0}})) begin
        drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
      end
    end
  end

  // Free output-FIFO slots, reserved at issue and returned on pop. Credit persists across jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= CREDIT_FULL;
      err_r    <= 1'b0;
    end else begin
      if (issue_s && !bus.Out_Pop) begin
        credit_r <= credit_r - WIDTH_CREDIT'(1);
      end else if (!issue_s && bus.Out_Pop) begin
        if (credit_r == CREDIT_FULL) begin
          err_r <= 1'b1;
        end else begin
          credit_r <= credit_r + WIDTH_CREDIT'(1);
        end
      end
    end
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DONE);
      if (start_acc_s) begin
        busy_r <= 1'b1;
      end else if (done_r) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign bus.EN_Rd_Fifo = issue_s;
  assign bus.bias_addrb = bias_r;
  assign bus.Busy       = busy_r;
  assign bus.Done       = done_r;
  assign bus.Credit_Err = err_r;

endmodule

// File: tb/tb_quan_credit_scheduler.sv
// Randomised and directed bench for quan_credit_scheduler, compared against a job-level
// reference of strobe counts, group addresses, output-FIFO occupancy and completion latency.
module tb_quan_credit_scheduler;

  localparam int DEPTH     = 32;
  localparam int SETTLE    = 3;
  localparam int LAT_ZERO  = 11;
  localparam int LAT_LEAKY = 16;

  logic clk;
  logic rst_n;

  quan_credit_scheduler_if intf ();

  quan_credit_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(intf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int model_credit;
  bit model_err;
  int strobe_cyc[$];
  int strobe_bias[$];
  int done_cnt, done_cyc, illegal_cnt;
  logic busy_at_done;

  // The model holds output-FIFO free space: DEPTH minus (words issued minus words popped).
  task automatic observe();
    bit issue;
    bit pop;
    issue = (intf.EN_Rd_Fifo === 1'b1);
    pop   = (intf.Out_Pop === 1'b1);
    if (issue) begin
      if (intf.Fifo_Ready !== 1'b1 || model_credit <= 0) illegal_cnt++;
      strobe_cyc.push_back(cyc_n);
      strobe_bias.push_back(int'(intf.bias_addrb));
    end
    if (intf.Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
      busy_at_done = intf.Busy;
    end
    if (issue && !pop) model_credit--;
    else if (!issue && pop) begin
      if (model_credit == DEPTH) model_err = 1'b1;
      else model_credit++;
    end
    cyc_n++;
  endtask

  task automatic cyc(input logic st, input logic rdy, input logic pop);
    intf.Start = st;
    intf.Fifo_Ready = rdy;
    intf.Out_Pop = pop;
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_job();
    strobe_cyc.delete();
    strobe_bias.delete();
    done_cnt = 0;
    done_cyc = -1;
    illegal_cnt = 0;
    busy_at_done = 1'b0;
  endtask

  function automatic logic rdy_val(input int mode, input int n);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[3 - (n % 4)];
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic pop_val(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  // Group index of strobe i is i / rows; count strobes that show another address.
  function automatic int bias_errors(input int rows);
    int bad = 0;
    for (int i = 0; i < strobe_bias.size(); i++)
      if (strobe_bias[i] != i / rows) bad++;
    return bad;
  endfunction

  function automatic int last_strobe();
    if (strobe_cyc.size() == 0) return -1000;
    return strobe_cyc[strobe_cyc.size() - 1];
  endfunction

  task automatic set_regs(input int rows, input int groups, input logic leaky);
    intf.Row_Num_Out_REG = 12'(rows);
    intf.Channel_Out_Num_REG = 10'(groups);
    intf.Leaky_REG = leaky;
  endtask

  task automatic run_job(input int rows, input int groups, input logic leaky,
                         input int rmode, input int pmode, input int budget, output int start_c);
    int n = 0;
    clear_job();
    set_regs(rows, groups, leaky);
    start_c = cyc_n;
    cyc(1'b1, rdy_val(rmode, 0), pop_val(pmode));
    while (done_cnt == 0 && n < budget) begin
      n++;
      cyc(1'b0, rdy_val(rmode, n), pop_val(pmode));
    end
  endtask

  task automatic test_reset();
    intf.Fifo_Ready = 1'b1;
    #1;
    tests++; if (intf.EN_Rd_Fifo !== 1'b0) begin fails++; $display("FAIL reset_en got=%b exp=0", intf.EN_Rd_Fifo); end
    tests++; if (intf.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", intf.Busy); end
    tests++; if (intf.Done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", intf.Done); end
    tests++; if (intf.bias_addrb !== 8'd0) begin fails++; $display("FAIL reset_bias got=%0d exp=0", intf.bias_addrb); end
    tests++; if (intf.Credit_Err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", intf.Credit_Err); end
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_credit_err();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    tests++; if (intf.Credit_Err !== model_err) begin fails++; $display("FAIL pop_at_full_err got=%b exp=%b", intf.Credit_Err, model_err); end
  endtask

  task automatic test_basic();
    int s;
    run_job(4, 2, 1'b1, 0, 1, 200, s);
    tests++; if (strobe_cyc.size() != 8) begin fails++; $display("FAIL basic_count got=%0d exp=8", strobe_cyc.size()); end
    tests++; if (strobe_cyc.size() > 0 && strobe_cyc[0] - s != SETTLE + 1) begin fails++; $display("FAIL basic_first got=%0d exp=%0d", strobe_cyc[0] - s, SETTLE + 1); end
    tests++; if (bias_errors(4) != 0) begin fails++; $display("FAIL basic_bias got=%0d bad exp=0", bias_errors(4)); end
    tests++; if (strobe_cyc.size() == 8 && strobe_cyc[4] - strobe_cyc[3] != SETTLE + 1) begin fails++; $display("FAIL basic_gap got=%0d exp=%0d", strobe_cyc[4] - strobe_cyc[3], SETTLE + 1); end
    tests++; if (done_cyc - last_strobe() != LAT_ZERO + 1) begin fails++; $display("FAIL basic_done_lat got=%0d exp=%0d", done_cyc - last_strobe(), LAT_ZERO + 1); end
    tests++; if (done_cnt != 1 || busy_at_done !== 1'b1) begin fails++; $display("FAIL basic_done got=%0d/busy=%b exp=1/1", done_cnt, busy_at_done); end
    tests++; if (intf.Busy !== 1'b0) begin fails++; $display("FAIL basic_busy_clear got=%b exp=0", intf.Busy); end
    tests++; if (intf.Credit_Err !== model_err) begin fails++; $display("FAIL basic_err got=%b exp=%b", intf.Credit_Err, model_err); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_job();
    set_regs(40, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b0);
    tests++; if (strobe_cyc.size() != DEPTH) begin fails++; $display("FAIL bp_stall got=%0d exp=%0d", strobe_cyc.size(), DEPTH); end
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
    tests++; if (strobe_cyc.size() != DEPTH + 1) begin fails++; $display("FAIL bp_one_pop got=%0d exp=%0d", strobe_cyc.size(), DEPTH + 1); end
    // A pop pulse then four cycles of issue+pop at credit 1, then one last strobe.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
    tests++; if (strobe_cyc.size() != DEPTH + 6) begin fails++; $display("FAIL bp_credit_one got=%0d exp=%0d", strobe_cyc.size(), DEPTH + 6); end
    while (done_cnt == 0 && n < 100) begin n++; cyc(1'b0, 1'b1, 1'b1); end
    tests++; if (strobe_cyc.size() != 40 || done_cnt != 1) begin fails++; $display("FAIL bp_total got=%0d/%0d exp=40/1", strobe_cyc.size(), done_cnt); end
    tests++; if (illegal_cnt != 0) begin fails++; $display("FAIL bp_illegal got=%0d exp=0", illegal_cnt); end
  endtask

  task automatic test_starvation();
    int s;
    run_job(5, 2, 1'b1, 1, 1, 300, s);
    tests++; if (strobe_cyc.size() != 10) begin fails++; $display("FAIL starve_count got=%0d exp=10", strobe_cyc.size()); end
    tests++; if (illegal_cnt != 0) begin fails++; $display("FAIL starve_illegal got=%0d exp=0", illegal_cnt); end
    tests++; if (bias_errors(5) != 0 || done_cyc - last_strobe() != LAT_ZERO + 1) begin fails++; $display("FAIL starve_done got=bad%0d/lat%0d exp=0/%0d", bias_errors(5), done_cyc - last_strobe(), LAT_ZERO + 1); end
  endtask

  task automatic test_leaky_zero();
    int s;
    run_job(1, 1, 1'b0, 0, 1, 100, s);
    tests++; if (strobe_cyc.size() != 1) begin fails++; $display("FAIL leaky_count got=%0d exp=1", strobe_cyc.size()); end
    tests++; if (done_cyc - last_strobe() != LAT_LEAKY + 1) begin fails++; $display("FAIL leaky_lat got=%0d exp=%0d", done_cyc - last_strobe(), LAT_LEAKY + 1); end
    run_job(0, 3, 1'b1, 0, 0, 50, s);
    tests++; if (strobe_cyc.size() != 0 || done_cnt != 1) begin fails++; $display("FAIL zero_rows got=%0d/%0d exp=0/1", strobe_cyc.size(), done_cnt); end
    tests++; if (done_cyc - s != 2) begin fails++; $display("FAIL zero_rows_lat got=%0d exp=2", done_cyc - s); end
    run_job(6, 0, 1'b0, 0, 0, 50, s);
    tests++; if (strobe_cyc.size() != 0 || done_cyc - s != 2) begin fails++; $display("FAIL zero_groups got=%0d/%0d exp=0/2", strobe_cyc.size(), done_cyc - s); end
  endtask

  task automatic test_start_busy();
    int n = 0;
    clear_job();
    set_regs(3, 2, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    while (done_cnt == 0 && n < 200) begin
      n++;
      if (n == 6 || n == 12) set_regs(9, 3, 1'b0);
      cyc((n == 6 || n == 12) ? 1'b1 : 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1);
    tests++; if (strobe_cyc.size() != 6 || done_cnt != 1) begin fails++; $display("FAIL start_busy got=%0d/%0d exp=6/1", strobe_cyc.size(), done_cnt); end
    tests++; if (bias_errors(3) != 0 || done_cyc - last_strobe() != LAT_ZERO + 1) begin fails++; $display("FAIL start_busy_job got=bad%0d/lat%0d exp=0/%0d", bias_errors(3), done_cyc - last_strobe(), LAT_ZERO + 1); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    int s;
    clear_job();
    set_regs(8, 2, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    while (strobe_cyc.size() < 5 && n < 100) begin n++; cyc(1'b0, 1'b1, 1'b1); end
    tests++; if (strobe_cyc.size() != 5) begin fails++; $display("FAIL rst_setup got=%0d exp=5", strobe_cyc.size()); end
    intf.Fifo_Ready = 1'b1;
    rst_n = 1'b0;
    #1;
    tests++; if (intf.EN_Rd_Fifo !== 1'b0 || intf.Busy !== 1'b0 || intf.Done !== 1'b0) begin fails++; $display("FAIL rst_async_ctl got=%b%b%b exp=000", intf.EN_Rd_Fifo, intf.Busy, intf.Done); end
    tests++; if (intf.bias_addrb !== 8'd0 || intf.Credit_Err !== 1'b0) begin fails++; $display("FAIL rst_async_bias got=%0d/%b exp=0/0", intf.bias_addrb, intf.Credit_Err); end
    model_credit = DEPTH;
    model_err = 1'b0;
    clear_job();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0);
    tests++; if (done_cnt != 0 || strobe_cyc.size() != 0) begin fails++; $display("FAIL rst_abandon got=%0d/%0d exp=0/0", done_cnt, strobe_cyc.size()); end
    run_job(4, 2, 1'b1, 0, 1, 200, s);
    tests++; if (strobe_cyc.size() != 8 || bias_errors(4) != 0) begin fails++; $display("FAIL rst_rerun got=%0d/bad%0d exp=8/0", strobe_cyc.size(), bias_errors(4)); end
    tests++; if (done_cyc - last_strobe() != LAT_ZERO + 1) begin fails++; $display("FAIL rst_rerun_lat got=%0d exp=%0d", done_cyc - last_strobe(), LAT_ZERO + 1); end
  endtask

  task automatic test_random();
    int s, rows, groups, lat;
    logic leaky;
    for (int j = 0; j < 6; j++) begin
      rows   = int'($urandom_range(1, 6));
      groups = int'($urandom_range(1, 3));
      leaky  = logic'($urandom_range(0, 1));
      lat    = leaky ? LAT_ZERO : LAT_LEAKY;
      run_job(rows, groups, leaky, 2, 2, 3000, s);
      tests++; if (strobe_cyc.size() != rows * groups || done_cnt != 1) begin fails++; $display("FAIL rand%0d_count got=%0d/%0d exp=%0d/1", j, strobe_cyc.size(), done_cnt, rows * groups); end
      tests++; if (bias_errors(rows) != 0 || illegal_cnt != 0) begin fails++; $display("FAIL rand%0d_bias got=bad%0d/illegal%0d exp=0/0", j, bias_errors(rows), illegal_cnt); end
      tests++; if (done_cyc - last_strobe() != lat + 1) begin fails++; $display("FAIL rand%0d_lat got=%0d exp=%0d", j, done_cyc - last_strobe(), lat + 1); end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, pop_val(2));
    end
    tests++; if (intf.Credit_Err !== model_err) begin fails++; $display("FAIL rand_err got=%b exp=%b", intf.Credit_Err, model_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    intf.Start = 1'b0;
    intf.Fifo_Ready = 1'b0;
    intf.Out_Pop = 1'b0;
    set_regs(0, 0, 1'b0);
    model_credit = DEPTH;
    model_err = 1'b0;
    clear_job();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_credit_err();
    test_backpressure();
    test_basic();
    test_starvation();
    test_leaky_zero();
    test_start_busy();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
